// File: rtl/bfp_block_align_pkg.sv
// Shared types for the block-exponent alignment stage: read FSM states and bank select.
package bfp_block_align_pkg;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_t;

  typedef logic bank_t;

endpackage

// File: rtl/bfp_pingpong_ram.sv
// Two-bank simple dual-port buffer; the bank select is the address MSB and reads are registered.
module bfp_pingpong_ram
  import bfp_block_align_pkg::*;
#(
  parameter int DATA_W = 38,
  parameter int ADDR_W = 11
) (
  input  logic              clk_sys,
  input  logic              wr_en,
  input  bank_t             wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  bank_t             rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_reg;

  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
    if (rd_en) rd_data_reg <= mem[{rd_bank, rd_addr}];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/bfp_block_align.sv
// Buffers complex blocks in ping-pong banks, tracks the block's largest exponent, and
// replays the block with every mantissa symmetrically rounded down to that common exponent.
module bfp_block_align
  import bfp_block_align_pkg::*;
#(
  parameter int MAN_WIDTH = 16,
  parameter int EXP_WIDTH = 6,
  parameter int MAX_LEN   = 2048,
  parameter int ADDR_W    = 11
) (
  input  logic                        clk_sys,
  input  logic                        rst_sys,
  input  logic                        block_sync_i,
  input  logic [ADDR_W:0]             blk_len_i,
  input  logic                        data_val_i,
  input  logic signed [MAN_WIDTH-1:0] data_real_i,
  input  logic signed [MAN_WIDTH-1:0] data_imag_i,
  input  logic signed [EXP_WIDTH-1:0] data_exp_i,
  output logic                        block_sync_o,
  output logic                        data_val_o,
  output logic signed [MAN_WIDTH-1:0] data_real_o,
  output logic signed [MAN_WIDTH-1:0] data_imag_o,
  output logic signed [EXP_WIDTH-1:0] data_exp_o,
  output logic                        err_o
);

  localparam int               DATA_W    = 2 * MAN_WIDTH + EXP_WIDTH;
  localparam logic [ADDR_W:0]    MAX_LEN_W = (ADDR_W+1)'(MAX_LEN);
  localparam logic [EXP_WIDTH:0] MAN_W_SH  = (EXP_WIDTH+1)'(MAN_WIDTH);

  // mantissa / 2^sh, ties away from zero; the -1 bias for negatives makes the floor shift symmetric
  function automatic logic signed [MAN_WIDTH-1:0] sym_shift(
    input logic signed [MAN_WIDTH-1:0] man,
    input logic [EXP_WIDTH:0]          sh
  );
    logic signed [MAN_WIDTH:0] sum;
    sum = {man[MAN_WIDTH-1], man} + ((MAN_WIDTH+1)'(1) << (sh - 1'b1))
          - (MAN_WIDTH+1)'(man[MAN_WIDTH-1]);
    if (sh == '0)            sym_shift = man;
    else if (sh >= MAN_W_SH) sym_shift = '0;
    else                     sym_shift = MAN_WIDTH'(sum >>> sh);
  endfunction

  // write side
  logic                        wr_active_reg, wr_active_next;
  logic [ADDR_W-1:0]           wr_addr_reg, wr_addr_next, wr_addr_cur;
  logic signed [EXP_WIDTH-1:0] wr_max_reg, wr_max_next, wr_max_cur;
  logic [ADDR_W:0]             wr_len_reg, wr_len_next, wr_len_cur;
  bank_t                       last_done_reg, wr_bank;
  logic                        wr_en, wr_complete, err_next, blk_start, len_ok;

  // per-bank state
  logic [1:0]                  bank_full, full_now;
  logic signed [EXP_WIDTH-1:0] bank_max [2];
  logic [ADDR_W:0]             bank_len [2];

  // read side
  rd_state_t                   state_reg, state_next;
  logic [ADDR_W-1:0]           rd_addr_reg, rd_addr_next;
  bank_t                       rd_bank_reg, rd_bank_next;
  logic                        rd_en, rd_release;
  logic                        rd_val_d1_reg, rd_first_d1_reg;
  logic signed [EXP_WIDTH-1:0] rd_max_d1_reg;
  logic [DATA_W-1:0]           ram_rd_data;
  logic signed [MAN_WIDTH-1:0] ram_real, ram_imag;
  logic signed [EXP_WIDTH-1:0] ram_exp;
  logic [EXP_WIDTH:0]          align_sh;

  // completions strictly alternate banks, so the next write always targets the other bank
  assign wr_bank   = ~last_done_reg;
  assign blk_start = block_sync_i & data_val_i;
  assign len_ok    = (blk_len_i != '0) && (blk_len_i <= MAX_LEN_W);

  always_comb begin
    err_next       = 1'b0;
    wr_en          = 1'b0;
    wr_complete    = 1'b0;
    wr_addr_cur    = wr_addr_reg;
    wr_max_cur     = wr_max_reg;
    wr_len_cur     = wr_len_reg;
    wr_active_next = wr_active_reg;
    wr_addr_next   = wr_addr_reg;
    wr_max_next    = wr_max_reg;
    wr_len_next    = wr_len_reg;
    if (blk_start) begin
      err_next       = wr_active_reg;
      wr_active_next = 1'b0;
      if (!len_ok || bank_full[wr_bank]) begin
        err_next = 1'b1;
      end else begin
        wr_en       = 1'b1;
        wr_addr_cur = '0;
        wr_max_cur  = data_exp_i;
        wr_len_cur  = blk_len_i;
      end
    end else if (data_val_i && wr_active_reg) begin
      wr_en      = 1'b1;
      wr_max_cur = (data_exp_i > wr_max_reg) ? data_exp_i : wr_max_reg;
    end
    if (wr_en) begin
      wr_complete    = (({1'b0, wr_addr_cur} + 1'b1) == wr_len_cur);
      wr_active_next = !wr_complete;
      wr_addr_next   = wr_addr_cur + 1'b1;
      wr_max_next    = wr_max_cur;
      wr_len_next    = wr_len_cur;
    end
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      wr_active_reg <= 1'b0;
      wr_addr_reg   <= '0;
      wr_max_reg    <= '0;
      wr_len_reg    <= '0;
      last_done_reg <= 1'b1;
    end else begin
      wr_active_reg <= wr_active_next;
      wr_addr_reg   <= wr_addr_next;
      wr_max_reg    <= wr_max_next;
      wr_len_reg    <= wr_len_next;
      if (wr_complete) last_done_reg <= wr_bank;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic                        full_reg, set_full, clr_full;
      logic signed [EXP_WIDTH-1:0] max_reg;
      logic [ADDR_W:0]             len_reg;

      assign set_full = wr_complete && (wr_bank == 1'(gi));
      assign clr_full = rd_release && (rd_bank_reg == 1'(gi));

      always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
          full_reg <= 1'b0;
          max_reg  <= '0;
          len_reg  <= '0;
        end else if (set_full) begin
          full_reg <= 1'b1;
          max_reg  <= wr_max_cur;
          len_reg  <= wr_len_cur;
        end else if (clr_full) begin
          full_reg <= 1'b0;
        end
      end

      // a bank completing this cycle counts as FULL so the read starts without a bubble
      assign bank_full[gi] = full_reg;
      assign full_now[gi]  = full_reg | set_full;
      assign bank_max[gi]  = max_reg;
      assign bank_len[gi]  = len_reg;
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    rd_addr_next = rd_addr_reg;
    rd_bank_next = rd_bank_reg;
    rd_en        = 1'b0;
    rd_release   = 1'b0;
    case (state_reg)
      RD_IDLE: begin
        if (full_now[rd_bank_reg]) begin
          state_next   = RD_READ;
          rd_addr_next = '0;
        end
      end
      RD_READ: begin
        rd_en = 1'b1;
        if ({1'b0, rd_addr_reg} == bank_len[rd_bank_reg] - 1'b1) begin
          rd_release   = 1'b1;
          rd_bank_next = ~rd_bank_reg;
          rd_addr_next = '0;
          state_next   = full_now[~rd_bank_reg] ? RD_READ : RD_IDLE;
        end else begin
          rd_addr_next = rd_addr_reg + 1'b1;
        end
      end
      default: state_next = RD_IDLE;
    endcase
  end

  bfp_pingpong_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_sys (clk_sys),
    .wr_en   (wr_en),
    .wr_bank (wr_bank),
    .wr_addr (wr_addr_cur),
    .wr_data ({data_real_i, data_imag_i, data_exp_i}),
    .rd_en   (rd_en),
    .rd_bank (rd_bank_reg),
    .rd_addr (rd_addr_reg),
    .rd_data (ram_rd_data)
  );

  assign ram_real = ram_rd_data[DATA_W-1 -: MAN_WIDTH];
  assign ram_imag = ram_rd_data[EXP_WIDTH +: MAN_WIDTH];
  assign ram_exp  = ram_rd_data[EXP_WIDTH-1:0];
  assign align_sh = {rd_max_d1_reg[EXP_WIDTH-1], rd_max_d1_reg} - {ram_exp[EXP_WIDTH-1], ram_exp};

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state_reg       <= RD_IDLE;
      rd_addr_reg     <= '0;
      rd_bank_reg     <= 1'b0;
      rd_val_d1_reg   <= 1'b0;
      rd_first_d1_reg <= 1'b0;
      rd_max_d1_reg   <= '0;
      data_val_o      <= 1'b0;
      block_sync_o    <= 1'b0;
      data_real_o     <= '0;
      data_imag_o     <= '0;
      data_exp_o      <= '0;
      err_o           <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rd_addr_reg     <= rd_addr_next;
      rd_bank_reg     <= rd_bank_next;
      rd_val_d1_reg   <= rd_en;
      rd_first_d1_reg <= rd_en && (rd_addr_reg == '0);
      rd_max_d1_reg   <= bank_max[rd_bank_reg];
      data_val_o      <= rd_val_d1_reg;
      block_sync_o    <= rd_first_d1_reg;
      err_o           <= err_next;
      if (rd_val_d1_reg) begin
        data_real_o <= sym_shift(ram_real, align_sh);
        data_imag_o <= sym_shift(ram_imag, align_sh);
        data_exp_o  <= rd_max_d1_reg;
      end else begin
        data_real_o <= '0;
        data_imag_o <= '0;
        data_exp_o  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bfp_block_align.sv
// Directed bench for bfp_block_align: table of single blocks plus hand-written multi-block sequences.
module tb_bfp_block_align;

  localparam int MW = 16;
  localparam int EW = 6;
  localparam int ML = 2048;
  localparam int AW = 11;

  logic                 clk_sys = 1'b0;
  logic                 rst_sys = 1'b1;
  logic                 block_sync_i = 1'b0;
  logic [AW:0]          blk_len_i = '0;
  logic                 data_val_i = 1'b0;
  logic signed [MW-1:0] data_real_i = '0;
  logic signed [MW-1:0] data_imag_i = '0;
  logic signed [EW-1:0] data_exp_i = '0;
  logic                 block_sync_o;
  logic                 data_val_o;
  logic signed [MW-1:0] data_real_o;
  logic signed [MW-1:0] data_imag_o;
  logic signed [EW-1:0] data_exp_o;
  logic                 err_o;

  always #5 clk_sys = ~clk_sys;

  bfp_block_align #(
    .MAN_WIDTH (MW),
    .EXP_WIDTH (EW),
    .MAX_LEN   (ML),
    .ADDR_W    (AW)
  ) dut (
    .clk_sys      (clk_sys),
    .rst_sys      (rst_sys),
    .block_sync_i (block_sync_i),
    .blk_len_i    (blk_len_i),
    .data_val_i   (data_val_i),
    .data_real_i  (data_real_i),
    .data_imag_i  (data_imag_i),
    .data_exp_i   (data_exp_i),
    .block_sync_o (block_sync_o),
    .data_val_o   (data_val_o),
    .data_real_o  (data_real_o),
    .data_imag_o  (data_imag_o),
    .data_exp_o   (data_exp_o),
    .err_o        (err_o)
  );

  typedef struct {
    int stamp;
    int sync;
    int re;
    int im;
    int ex;
  } cap_t;

  typedef struct {
    int len;
    int re[8];
    int im[8];
    int ex[8];
    int exp_o;
    int re_o[8];
    int im_o[8];
  } vec_t;

  cap_t q[$];
  vec_t vecs[5];
  int   cyc = 0;
  int   err_cnt = 0;
  int   err_stamp = -1;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk_sys) cyc++;

  always @(negedge clk_sys) begin
    if (data_val_o) begin
      q.push_back('{cyc, int'(block_sync_o), int'(data_real_o), int'(data_imag_o), int'(data_exp_o)});
      $display("[TB] out t=%0d sync=%0d re=%0d im=%0d exp=%0d",
               cyc, block_sync_o, data_real_o, data_imag_o, data_exp_o);
    end
    if (err_o) begin
      err_cnt++;
      err_stamp = cyc;
      $display("[TB] err_o pulse t=%0d", cyc);
    end
  end

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_block(input int len_field, input int n, input int re[8], input int im[8],
                            input int ex[8]);
    for (int k = 0; k < n; k++) begin
      block_sync_i = (k == 0);
      data_val_i   = 1'b1;
      blk_len_i    = (AW+1)'(len_field);
      data_real_i  = MW'(re[k]);
      data_imag_i  = MW'(im[k]);
      data_exp_i   = EW'(ex[k]);
      tick();
    end
  endtask

  task automatic idle(input int n);
    block_sync_i = 1'b0;
    data_val_i   = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wait_outputs(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (q.size() < n && c < budget) begin
      tick();
      c++;
    end
    tests++;
    if (q.size() < n) begin
      fails++;
      $display("FAIL %s timeout: got %0d samples, expected %0d", name, q.size(), n);
    end
  endtask

  task automatic clear_capture();
    q.delete();
    err_cnt   = 0;
    err_stamp = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_edge;
    int n_rst;
    int a_re[8], a_ex[8], b_re[8], b_ex[8], z8[8], c_re[8], exp_b[8];

    vecs[0] = '{4, '{1000, -1000, 3, 16384, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0},
                '{2, 5, 3, 5, 0, 0, 0, 0}, 5,
                '{125, -1000, 1, 16384, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[1] = '{6, '{0, 3, -3, 1, -1, 2, 0, 0}, '{0, -3, 3, -1, 1, -2, 0, 0},
                '{1, 0, 0, 0, 0, 0, 0, 0}, 1,
                '{0, 2, -2, 1, -1, 1, 0, 0}, '{0, -2, 2, -1, 1, -1, 0, 0}};
    vecs[2] = '{4, '{0, -32768, -32768, -32768, 0, 0, 0, 0}, '{7, 32767, -2, 5, 0, 0, 0, 0},
                '{20, 5, 4, 0, 0, 0, 0, 0}, 20,
                '{0, -1, 0, 0, 0, 0, 0, 0}, '{7, 1, 0, 0, 0, 0, 0, 0}};
    vecs[3] = '{4, '{100, -100, 9, -7, 0, 0, 0, 0}, '{1, 2, 3, -4, 0, 0, 0, 0},
                '{-3, -5, -4, -3, 0, 0, 0, 0}, -3,
                '{100, -25, 5, -7, 0, 0, 0, 0}, '{1, 1, 2, -4, 0, 0, 0, 0}};
    vecs[4] = '{1, '{1234, 0, 0, 0, 0, 0, 0, 0}, '{-5, 0, 0, 0, 0, 0, 0, 0},
                '{-32, 0, 0, 0, 0, 0, 0, 0}, -32,
                '{1234, 0, 0, 0, 0, 0, 0, 0}, '{-5, 0, 0, 0, 0, 0, 0, 0}};

    // reset state
    repeat (3) tick();
    check("reset data_val_o", int'(data_val_o), 0);
    check("reset block_sync_o", int'(block_sync_o), 0);
    check("reset data_real_o", int'(data_real_o), 0);
    check("reset data_imag_o", int'(data_imag_o), 0);
    check("reset data_exp_o", int'(data_exp_o), 0);
    check("reset err_o", int'(err_o), 0);
    rst_sys = 1'b0;
    idle(2);

    // single-block table
    for (int i = 0; i < 5; i++) begin
      clear_capture();
      send_block(vecs[i].len, vecs[i].len, vecs[i].re, vecs[i].im, vecs[i].ex);
      last_edge = cyc;
      idle(0);
      wait_outputs(vecs[i].len, 40, $sformatf("vec%0d", i));
      idle(10);
      check($sformatf("vec%0d count", i), q.size(), vecs[i].len);
      if (q.size() > 0) check($sformatf("vec%0d latency", i), q[0].stamp, last_edge + 2);
      for (int k = 0; k < q.size() && k < vecs[i].len; k++) begin
        check($sformatf("vec%0d[%0d] real", i, k), q[k].re, vecs[i].re_o[k]);
        check($sformatf("vec%0d[%0d] imag", i, k), q[k].im, vecs[i].im_o[k]);
        check($sformatf("vec%0d[%0d] exp", i, k), q[k].ex, vecs[i].exp_o);
        check($sformatf("vec%0d[%0d] sync", i, k), q[k].sync, (k == 0) ? 1 : 0);
      end
      check($sformatf("vec%0d err count", i), err_cnt, 0);
    end

    // back-to-back len-8 blocks: 16 contiguous outputs
    clear_capture();
    z8    = '{0, 0, 0, 0, 0, 0, 0, 0};
    a_re  = '{0, 10, 20, 30, 40, 50, 60, 70};
    a_ex  = '{3, 3, 3, 3, 3, 3, 3, 3};
    b_re  = '{100, 100, 100, 100, 100, 100, 100, 100};
    b_ex  = '{7, 6, 5, 4, 3, 2, 1, 0};
    exp_b = '{100, 50, 25, 13, 6, 3, 2, 1};
    send_block(8, 8, a_re, z8, a_ex);
    last_edge = cyc;
    send_block(8, 8, b_re, z8, b_ex);
    idle(0);
    wait_outputs(16, 60, "b2b");
    idle(10);
    check("b2b count", q.size(), 16);
    if (q.size() > 0) check("b2b latency", q[0].stamp, last_edge + 2);
    for (int k = 1; k < q.size() && k < 16; k++)
      check($sformatf("b2b[%0d] contiguous", k), q[k].stamp, q[0].stamp + k);
    for (int k = 0; k < q.size() && k < 16; k++) begin
      check($sformatf("b2b[%0d] real", k), q[k].re, (k < 8) ? a_re[k] : exp_b[k-8]);
      check($sformatf("b2b[%0d] exp", k), q[k].ex, (k < 8) ? 3 : 7);
      check($sformatf("b2b[%0d] sync", k), q[k].sync, (k == 0 || k == 8) ? 1 : 0);
    end

    // overflow: len 8, 2, 2 back-to-back -> third block dropped
    clear_capture();
    a_ex = '{0, 0, 0, 0, 0, 0, 0, 0};
    b_re = '{11, 12, 0, 0, 0, 0, 0, 0};
    c_re = '{21, 22, 0, 0, 0, 0, 0, 0};
    send_block(8, 8, a_re, z8, a_ex);
    send_block(2, 2, b_re, z8, a_ex);
    last_edge = cyc;
    send_block(2, 2, c_re, z8, a_ex);
    idle(0);
    wait_outputs(10, 60, "ovf");
    idle(20);
    check("ovf count", q.size(), 10);
    check("ovf err count", err_cnt, 1);
    check("ovf err timing", err_stamp, last_edge + 1);
    for (int k = 0; k < q.size() && k < 10; k++)
      check($sformatf("ovf[%0d] real", k), q[k].re, (k < 8) ? a_re[k] : b_re[k-8]);
    if (q.size() > 8) check("ovf second sync", q[8].sync, 1);

    // abort: sync mid-block restarts with the new block
    clear_capture();
    a_re = '{1, 2, 0, 0, 0, 0, 0, 0};
    b_re = '{300, 400, 0, 0, 0, 0, 0, 0};
    b_ex = '{0, 1, 0, 0, 0, 0, 0, 0};
    send_block(4, 2, a_re, z8, a_ex);
    send_block(2, 2, b_re, z8, b_ex);
    idle(0);
    wait_outputs(2, 40, "abort");
    idle(15);
    check("abort count", q.size(), 2);
    check("abort err count", err_cnt, 1);
    if (q.size() > 1) begin
      check("abort[0] real", q[0].re, 150);
      check("abort[1] real", q[1].re, 400);
      check("abort exp", q[0].ex, 1);
    end

    // illegal lengths 0 and MAX_LEN+1
    clear_capture();
    send_block(0, 1, b_re, z8, b_ex);
    idle(3);
    send_block(ML + 1, 2, b_re, z8, b_ex);
    idle(20);
    check("illegal err count", err_cnt, 2);
    check("illegal count", q.size(), 0);

    // reset asserted mid-read
    clear_capture();
    a_re = '{100, 200, 300, 400, 500, 600, 700, 800};
    a_ex = '{3, 3, 3, 3, 3, 3, 3, 3};
    send_block(8, 8, a_re, z8, a_ex);
    idle(0);
    wait_outputs(3, 40, "rst");
    rst_sys = 1'b1;
    #1;
    check("rst data_val_o", int'(data_val_o), 0);
    check("rst data_real_o", int'(data_real_o), 0);
    check("rst data_exp_o", int'(data_exp_o), 0);
    check("rst block_sync_o", int'(block_sync_o), 0);
    n_rst = q.size();
    tick();
    tick();
    rst_sys = 1'b0;
    idle(30);
    check("rst no output after release", q.size(), n_rst);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
